cdi_bus_sequencer: RTL and testbench

- Registered bus-cycle controller between the SCC68070 and the CD-i peripherals: ROM, slave µC, CDIC, NVRAM and MCD212.
- Decodes each CPU strobe into exactly one target and asserts that target's select.
- Waits for the target's acknowledge, then returns read data and a one-cycle bus_ack or bus_err to the CPU.
- Replaces the ad-hoc combinational ack/data muxing at top level with a deterministic FSM that includes an optional timeout.

---
 rtl/cdi_bus_pkg.sv | 35 +++
 rtl/cdi_addr_decode.sv | 30 +++
 rtl/cdi_bus_sequencer.sv | 179 +++++++++++++++++
 tb/tb_cdi_bus_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdi_bus_pkg.sv
// rtl/cdi_bus_pkg.sv - shared types and address map constants for the CD-i bus sequencer
package cdi_bus_pkg;

    // Peripheral a CPU cycle is routed to; TGT_NONE only appears out of reset
    typedef enum logic [2:0] {
        TGT_NONE,
        TGT_ROM,
        TGT_SLAVE,
        TGT_CDIC,
        TGT_NVRAM,
        TGT_MCD212,
        TGT_ERR
    } bus_target_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } bus_state_e;

    // Byte-address map of the CD-i bus
    localparam logic [23:0] ERR1_LO    = 24'h600000;
    localparam logic [23:0] ERR1_HI    = 24'hD00000;
    localparam logic [23:0] ERR2_LO    = 24'hF00000;
    localparam logic [23:0] MCD_LO_MAX = 24'h27FFFF;
    localparam logic [23:0] MCD_HI_MIN = 24'h400000;

    localparam logic [7:0] PAGE_CDIC  = 8'h30;
    localparam logic [7:0] PAGE_SLAVE = 8'h31;
    localparam logic [7:0] PAGE_NVRAM = 8'h32;

    // Width of the optional ACCESS timeout counter
    localparam int CNT_W = 10;

endpackage

// File: rtl/cdi_addr_decode.sv
// rtl/cdi_addr_decode.sv - combinational byte-address / csrom to bus target decode
module cdi_addr_decode
    import cdi_bus_pkg::*;
(
    input  logic [23:0] i_addr,
    input  logic        i_csrom,
    output bus_target_e o_target
);

    // Priority decode: hard error holes first, then boot ROM mapping, then pages
    always_comb begin
        o_target = TGT_ERR;
        if (((i_addr >= ERR1_LO) && (i_addr < ERR1_HI)) || (i_addr >= ERR2_LO)) begin
            o_target = TGT_ERR;
        end else if (i_csrom) begin
            o_target = TGT_ROM;
        end else if (i_addr[23:16] == PAGE_SLAVE) begin
            o_target = TGT_SLAVE;
        end else if (i_addr[23:16] == PAGE_CDIC) begin
            o_target = TGT_CDIC;
        end else if (i_addr[23:16] == PAGE_NVRAM) begin
            o_target = TGT_NVRAM;
        end else if (!i_addr[23] && ((i_addr <= MCD_LO_MAX) || (i_addr >= MCD_HI_MIN))) begin
            o_target = TGT_MCD212;
        end else begin
            o_target = TGT_ERR;
        end
    end

endmodule

// File: rtl/cdi_bus_sequencer.sv
// rtl/cdi_bus_sequencer.sv - SCC68070 bus-cycle FSM for CD-i peripherals (optional timeout: CDI_BUS_TIMEOUT_EN)
module cdi_bus_sequencer
    import cdi_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_as,
    input  logic              cpu_uds,
    input  logic              cpu_lds,
    input  logic              cpu_write_strobe,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [15:0]       cpu_din,
    output logic              cpu_bus_ack,
    output logic              cpu_bus_err,
    input  logic              csrom,
    output logic              cs_rom,
    output logic              cs_slave,
    output logic              cs_cdic,
    output logic              cs_nvram,
    output logic              cs_mcd212,
    input  logic              ack_rom,
    input  logic              ack_slave,
    input  logic              ack_cdic,
    input  logic              ack_nvram,
    input  logic              ack_mcd212,
    input  logic [15:0]       dout_rom,
    input  logic [15:0]       dout_slave,
    input  logic [15:0]       dout_cdic,
    input  logic [15:0]       dout_nvram,
    input  logic [15:0]       dout_mcd212,
    output logic              busy
);

    bus_state_e  r_state;
    bus_state_e  w_next;
    bus_target_e r_target;
    bus_target_e w_dec_target;
    logic        r_write;
    logic        r_ack;
    logic        r_err;
    logic [15:0] r_din;
    logic [23:0] w_byte_addr;
    logic        w_start;
    logic        w_ack_sel;
    logic        w_tmo;
    logic [15:0] w_dout_sel;

    assign w_byte_addr = 24'({cpu_addr, 1'b0});
    assign w_start     = cpu_as && (cpu_uds || cpu_lds);

    cdi_addr_decode u_decode (
        .i_addr   (w_byte_addr),
        .i_csrom  (csrom),
        .o_target (w_dec_target)
    );

    // Route only the latched target's ack and data; other acks are ignored
    always_comb begin
        w_ack_sel  = 1'b0;
        w_dout_sel = 16'h0000;
        case (r_target)
            TGT_ROM:    begin w_ack_sel = ack_rom;    w_dout_sel = dout_rom;    end
            TGT_SLAVE:  begin w_ack_sel = ack_slave;  w_dout_sel = dout_slave;  end
            TGT_CDIC:   begin w_ack_sel = ack_cdic;   w_dout_sel = dout_cdic;   end
            TGT_NVRAM:  begin w_ack_sel = ack_nvram;  w_dout_sel = dout_nvram;  end
            TGT_MCD212: begin w_ack_sel = ack_mcd212; w_dout_sel = dout_mcd212; end
            default:    ;
        endcase
    end

`ifdef CDI_BUS_TIMEOUT_EN
    logic [CNT_W-1:0] r_count;

    // Count ACCESS cycles without ack; IDLE always precedes ACCESS so it clears here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (r_state == ST_IDLE) begin
            r_count <= '0;
        end else if ((r_state == ST_ACCESS) && !w_ack_sel) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign w_tmo = (r_state == ST_ACCESS) && (r_target != TGT_ERR) && !w_ack_sel &&
                   (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_tmo        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: abort on strobe loss, finish on ack/err/timeout, DONE waits for strobe release
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!cpu_as) begin
                    w_next = ST_IDLE;
                end else if ((r_target == TGT_ERR) || w_ack_sel || w_tmo) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!cpu_as) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Latch the cycle, capture read data and form the one-cycle ack/err pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_target <= TGT_NONE;
            r_write  <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_din    <= 16'h0000;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_target <= w_dec_target;
                        r_write  <= cpu_write_strobe;
                        r_err    <= (w_dec_target == TGT_ERR);
                    end
                end
                ST_ACCESS: begin
                    if (cpu_as) begin
                        if (w_ack_sel) begin
                            r_ack <= 1'b1;
                            if (!r_write) begin
                                r_din <= w_dout_sel;
                            end
                        end else if (w_tmo) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Selects follow the state so an async reset drops them at once
    always_comb begin
        cs_rom      = (r_state == ST_ACCESS) && (r_target == TGT_ROM);
        cs_slave    = (r_state == ST_ACCESS) && (r_target == TGT_SLAVE);
        cs_cdic     = (r_state == ST_ACCESS) && (r_target == TGT_CDIC);
        cs_nvram    = (r_state == ST_ACCESS) && (r_target == TGT_NVRAM);
        cs_mcd212   = (r_state == ST_ACCESS) && (r_target == TGT_MCD212);
        busy        = (r_state != ST_IDLE);
        cpu_bus_ack = r_ack;
        cpu_bus_err = r_err;
        cpu_din     = r_din;
    end

endmodule

// File: tb/tb_cdi_bus_sequencer.sv
// tb/tb_cdi_bus_sequencer.sv - scoreboard bench for the CD-i bus sequencer
module tb_cdi_bus_sequencer;

    typedef struct packed {
        logic        is_err;
        logic [15:0] din;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_as = 1'b0;
    logic        cpu_uds = 1'b0;
    logic        cpu_lds = 1'b0;
    logic        cpu_write_strobe = 1'b0;
    logic [22:0] cpu_addr = '0;
    logic        csrom = 1'b0;
    logic [4:0]  ack_vec = '0;
    logic [15:0] dout_rom = '0, dout_slave = '0, dout_cdic = '0, dout_nvram = '0, dout_mcd212 = '0;
    logic [15:0] cpu_din;
    logic        cpu_bus_ack, cpu_bus_err, busy;
    logic        cs_rom, cs_slave, cs_cdic, cs_nvram, cs_mcd212;
    logic [4:0]  cs_vec;

    resp_t       sb_q[$];
    int          errors = 0;
    int          checks = 0;

    assign cs_vec = {cs_mcd212, cs_nvram, cs_cdic, cs_slave, cs_rom};

    always #5 clk = ~clk;

    cdi_bus_sequencer #(.TIMEOUT_CYCLES(16), .ADDR_W(23)) dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_as           (cpu_as),
        .cpu_uds          (cpu_uds),
        .cpu_lds          (cpu_lds),
        .cpu_write_strobe (cpu_write_strobe),
        .cpu_addr         (cpu_addr),
        .cpu_din          (cpu_din),
        .cpu_bus_ack      (cpu_bus_ack),
        .cpu_bus_err      (cpu_bus_err),
        .csrom            (csrom),
        .cs_rom           (cs_rom),
        .cs_slave         (cs_slave),
        .cs_cdic          (cs_cdic),
        .cs_nvram         (cs_nvram),
        .cs_mcd212        (cs_mcd212),
        .ack_rom          (ack_vec[0]),
        .ack_slave        (ack_vec[1]),
        .ack_cdic         (ack_vec[2]),
        .ack_nvram        (ack_vec[3]),
        .ack_mcd212       (ack_vec[4]),
        .dout_rom         (dout_rom),
        .dout_slave       (dout_slave),
        .dout_cdic        (dout_cdic),
        .dout_nvram       (dout_nvram),
        .dout_mcd212      (dout_mcd212),
        .busy             (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every ack/err the DUT presents must match the oldest expected response
    always @(negedge clk) begin
        if (cpu_bus_ack || cpu_bus_err) begin
            chk("ack_err_exclusive", {31'b0, cpu_bus_ack & cpu_bus_err}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_resp", {30'b0, cpu_bus_ack, cpu_bus_err}, 32'd0);
            end else begin
                resp_t e;
                e = sb_q.pop_front();
                chk("sb_resp_kind", {31'b0, cpu_bus_err}, {31'b0, e.is_err});
                chk("sb_resp_din", {16'b0, cpu_din}, {16'b0, e.din});
            end
        end
    end

    task automatic drive(input logic [23:0] a, input logic wr, input logic u, input logic l, input logic rom);
        logic [23:0] av;
        av = a;
        cpu_addr         = av[23:1];
        cpu_write_strobe = wr;
        cpu_uds          = u;
        cpu_lds          = l;
        csrom            = rom;
        cpu_as           = 1'b1;
    endtask

    task automatic release_as();
        cpu_as  = 1'b0;
        cpu_uds = 1'b0;
        cpu_lds = 1'b0;
        csrom   = 1'b0;
    endtask

    // Normal cycle; non-selected targets ack while the selected one is still waiting
    task automatic bus_cycle(input string nm, input logic [23:0] a, input logic wr, input logic u,
                             input logic l, input logic rom, input logic [4:0] exp_cs,
                             input int ack_after, input logic [15:0] v, input logic [15:0] exp_din);
        resp_t r;
        dout_rom    = exp_cs[0] ? v : 16'hDEAD;
        dout_slave  = exp_cs[1] ? v : 16'hDEAD;
        dout_cdic   = exp_cs[2] ? v : 16'hDEAD;
        dout_nvram  = exp_cs[3] ? v : 16'hDEAD;
        dout_mcd212 = exp_cs[4] ? v : 16'hDEAD;
        r.is_err = 1'b0;
        r.din    = exp_din;
        sb_q.push_back(r);
        drive(a, wr, u, l, rom);
        tick();
        for (int k = 1; k <= ack_after; k++) begin
            chk({nm, "_cs"}, {27'b0, cs_vec}, {27'b0, exp_cs});
            chk({nm, "_no_early_ack"}, {31'b0, cpu_bus_ack}, 32'd0);
            ack_vec = (k == ack_after) ? exp_cs : (~exp_cs & 5'h1F);
            tick();
        end
        ack_vec = '0;
        chk({nm, "_cs_off"}, {27'b0, cs_vec}, 32'd0);
        chk({nm, "_ack"}, {31'b0, cpu_bus_ack}, 32'd1);
        chk({nm, "_din"}, {16'b0, cpu_din}, {16'b0, exp_din});
        tick();
        chk({nm, "_done_busy"}, {31'b0, busy}, 32'd1);
        chk({nm, "_single_ack"}, {31'b0, cpu_bus_ack}, 32'd0);
        release_as();
        tick();
        chk({nm, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic err_cycle(input string nm, input logic [23:0] a, input logic rom, input logic [15:0] exp_din);
        resp_t r;
        r.is_err = 1'b1;
        r.din    = exp_din;
        sb_q.push_back(r);
        drive(a, 1'b0, 1'b1, 1'b1, rom);
        tick();
        chk({nm, "_no_cs"}, {27'b0, cs_vec}, 32'd0);
        chk({nm, "_err"}, {31'b0, cpu_bus_err}, 32'd1);
        tick();
        chk({nm, "_err_once"}, {31'b0, cpu_bus_err}, 32'd0);
        tick();
        chk({nm, "_done_hold"}, {31'b0, busy}, 32'd1);
        release_as();
        tick();
        chk({nm, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        resp_t r;
        tick();
        chk("rst_cs", {27'b0, cs_vec}, 32'd0);
        chk("rst_ack", {31'b0, cpu_bus_ack}, 32'd0);
        chk("rst_err", {31'b0, cpu_bus_err}, 32'd0);
        chk("rst_din", {16'b0, cpu_din}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        bus_cycle("rom_rd",    24'h000100, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00001, 1, 16'h4AFC, 16'h4AFC);
        bus_cycle("nvram_wr",  24'h320010, 1'b1, 1'b1, 1'b0, 1'b0, 5'b01000, 3, 16'h9292, 16'h4AFC);
        err_cycle("err_700000", 24'h700000, 1'b0, 16'h4AFC);

        // Abort: strobe drops after two selected cycles with no ack
        drive(24'h310000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("abort_cs1", {27'b0, cs_vec}, 32'd2);
        tick();
        chk("abort_cs2", {27'b0, cs_vec}, 32'd2);
        release_as();
        tick();
        chk("abort_idle", {31'b0, busy}, 32'd0);
        chk("abort_cs_off", {27'b0, cs_vec}, 32'd0);
        tick();

        bus_cycle("cdic_rd",   24'h303C00, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00100, 1, 16'h3C3C, 16'h3C3C);
        bus_cycle("mcd_lo_max", 24'h27FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10000, 2, 16'h2121, 16'h2121);
        err_cycle("err_280000", 24'h280000, 1'b0, 16'h2121);
        bus_cycle("mcd_hi_min", 24'h400000, 1'b0, 1'b1, 1'b1, 1'b0, 5'b10000, 1, 16'h1234, 16'h1234);
        bus_cycle("mcd_5ffffe", 24'h5FFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 5'b10000, 1, 16'h5FFE, 16'h5FFE);
        err_cycle("err_600000", 24'h600000, 1'b0, 16'h5FFE);
        err_cycle("err_f00000_rom", 24'hF00000, 1'b1, 16'h5FFE);
        bus_cycle("rom_over_slave", 24'h310000, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00001, 1, 16'h0BEE, 16'h0BEE);
        bus_cycle("slave_rd",  24'h310042, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00010, 2, 16'h5151, 16'h5151);
        bus_cycle("mcd_ack16", 24'h200000, 1'b0, 1'b1, 1'b1, 1'b0, 5'b10000, 16, 16'h0016, 16'h0016);

`ifdef CDI_BUS_TIMEOUT_EN
        // Timeout: sixteen ACCESS cycles without ack end in bus error
        r.is_err = 1'b1;
        r.din    = 16'h0016;
        sb_q.push_back(r);
        drive(24'h200000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 16; k++) begin
            chk("tmo_cs", {27'b0, cs_vec}, 32'h10);
            chk("tmo_no_err_yet", {31'b0, cpu_bus_err}, 32'd0);
            tick();
        end
        chk("tmo_err", {31'b0, cpu_bus_err}, 32'd1);
        chk("tmo_cs_off", {27'b0, cs_vec}, 32'd0);
        tick();
        chk("tmo_done_hold", {31'b0, busy}, 32'd1);
        release_as();
        tick();
        chk("tmo_idle", {31'b0, busy}, 32'd0);
`else
        // No timeout: a very late ack still completes the cycle
        bus_cycle("mcd_ack40", 24'h200000, 1'b0, 1'b1, 1'b1, 1'b0, 5'b10000, 40, 16'h0040, 16'h0040);
`endif

        // Async reset in the middle of a CDIC access
        dout_cdic = 16'h7777;
        drive(24'h300000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("arst_cs_before", {27'b0, cs_vec}, 32'd4);
        #2;
        reset   = 1'b0;
        ack_vec = 5'b00100;
        #1;
        chk("arst_cs_drop", {27'b0, cs_vec}, 32'd0);
        chk("arst_busy_drop", {31'b0, busy}, 32'd0);
        tick();
        release_as();
        ack_vec = '0;
        reset   = 1'b1;
        tick();
        chk("arst_idle", {31'b0, busy}, 32'd0);
        chk("arst_din", {16'b0, cpu_din}, 32'd0);
        tick();

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
